parity_frame_tx: RTL and testbench

//   Serializes a parallel data word onto a one-bit line, LSB first, followed by
//   a single parity bit. Parity is computed bit by bit with a running XOR

---
 rtl/parity_frame_tx_if.sv | 23 ++
 rtl/parity_frame_tx.sv | 134 +++++++++++++
 tb/tb_parity_frame_tx.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_tx_if.sv
// Word-in / serial-out bundle for parity_frame_tx.
interface parity_frame_tx_if #(
   parameter int unsigned DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              odd_sel;
   logic              ser_out;
   logic              ser_valid;
   logic              ser_par;
   logic              done;

   modport master (
      output in_data, in_valid, odd_sel,
      input  in_ready, ser_out, ser_valid, ser_par, done
   );

   modport slave (
      input  in_data, in_valid, odd_sel,
      output in_ready, ser_out, ser_valid, ser_par, done
   );
endinterface

// File: rtl/parity_frame_tx.sv
// Serializes a word LSB first followed by one even/odd parity bit,
// each bit held for DIV cycles; parity built with a running XOR.
module parity_frame_tx #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIV    = 1
) (
   input  logic              clk,
   input  logic              rst,
   parity_frame_tx_if.slave  bus
);
   localparam int unsigned BIT_CW = $clog2(DATA_W + 1);
   localparam int unsigned DIV_CW = $clog2(DIV + 1);
   localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(DATA_W - 1);
   localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_PARITY,
      S_DONE
   } state_t;

   state_t              state, state_n;
   logic [DATA_W-1:0]   shreg, shreg_n;
   logic                acc, acc_n;
   logic [BIT_CW-1:0]   bit_cnt, bit_cnt_n;
   logic [DIV_CW-1:0]   div_cnt, div_cnt_n;
   logic                ser_out_q, ser_out_n;
   logic                ser_valid_q, ser_valid_n;
   logic                ser_par_q, ser_par_n;
   logic                done_q, done_n;
   logic                ready_c;
   logic                accept_c;

   // Ready is decoded straight from state so it drops in the very cycle rst is high.
   assign ready_c  = ~rst & ((state == S_IDLE) | (state == S_DONE));
   assign accept_c = bus.in_valid & ready_c;

   assign bus.in_ready  = ready_c;
   assign bus.ser_out   = ser_out_q;
   assign bus.ser_valid = ser_valid_q;
   assign bus.ser_par   = ser_par_q;
   assign bus.done      = done_q;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         shreg       <= '0;
         acc         <= 1'b0;
         bit_cnt     <= '0;
         div_cnt     <= '0;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_par_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state       <= state_n;
         shreg       <= shreg_n;
         acc         <= acc_n;
         bit_cnt     <= bit_cnt_n;
         div_cnt     <= div_cnt_n;
         ser_out_q   <= ser_out_n;
         ser_valid_q <= ser_valid_n;
         ser_par_q   <= ser_par_n;
         done_q      <= done_n;
      end
   end

   // Next-state, datapath update, and next-cycle output values.
   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      acc_n     = acc;
      bit_cnt_n = bit_cnt;
      div_cnt_n = div_cnt;

      unique case (state)
         S_IDLE, S_DONE: begin
            state_n = S_IDLE;
            if (accept_c) begin
               shreg_n   = bus.in_data;
               acc_n     = bus.odd_sel;
               bit_cnt_n = '0;
               div_cnt_n = '0;
               state_n   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (div_cnt == DIV_LAST) begin
               div_cnt_n = '0;
               acc_n     = acc ^ shreg[0];
               shreg_n   = shreg >> 1;
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt_n = '0;
                  state_n   = S_PARITY;
               end else begin
                  bit_cnt_n = bit_cnt + BIT_CW'(1);
               end
            end else begin
               div_cnt_n = div_cnt + DIV_CW'(1);
            end
         end
         S_PARITY: begin
            if (div_cnt == DIV_LAST) begin
               div_cnt_n = '0;
               state_n   = S_DONE;
            end else begin
               div_cnt_n = div_cnt + DIV_CW'(1);
            end
         end
         default: state_n = S_IDLE;
      endcase

      // Outputs reflect the state being entered so they line up with it after the edge.
      ser_out_n   = 1'b0;
      ser_valid_n = 1'b0;
      ser_par_n   = 1'b0;
      done_n      = 1'b0;
      unique case (state_n)
         S_SHIFT: begin
            ser_out_n   = shreg_n[0];
            ser_valid_n = 1'b1;
         end
         S_PARITY: begin
            ser_out_n   = acc_n;
            ser_valid_n = 1'b1;
            ser_par_n   = 1'b1;
         end
         S_DONE:  done_n = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: one DUT with DIV=1, one with DIV=4.
module tb_parity_frame_tx;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   parity_frame_tx_if #(.DATA_W(8)) bus_a ();
   parity_frame_tx_if #(.DATA_W(8)) bus_b ();

   parity_frame_tx #(.DATA_W(8), .DIV(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   parity_frame_tx #(.DATA_W(8), .DIV(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends one word on DUT A and records T+1..T+9 line values plus done over T+1..T+10.
   task automatic xfer_a(input logic [7:0] d, input logic o, input bit toggle,
                         output logic [8:0] bits, output logic [8:0] vals,
                         output logic [8:0] pars, output logic [9:0] dones,
                         output logic rdy);
      bus_a.in_data  = d;
      bus_a.odd_sel  = o;
      bus_a.in_valid = 1'b1;
      tick();
      bus_a.in_valid = 1'b0;
      rdy = bus_a.in_ready;
      for (int i = 0; i < 9; i++) begin
         bits[i]  = bus_a.ser_out;
         vals[i]  = bus_a.ser_valid;
         pars[i]  = bus_a.ser_par;
         dones[i] = bus_a.done;
         if (toggle) begin
            bus_a.in_data = ~bus_a.in_data;
            bus_a.odd_sel = ~bus_a.odd_sel;
         end
         tick();
      end
      dones[9] = bus_a.done;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 8'hFF;
      tick();
      tick();
      n_cmp++;
      if (bus_a.in_ready !== 1'b0) begin
         n_err++; $display("FAIL reset_in_ready: got %b want 0", bus_a.in_ready);
      end
      n_cmp++;
      if ({bus_a.ser_out, bus_a.ser_valid, bus_a.ser_par, bus_a.done} !== 4'b0000) begin
         n_err++; $display("FAIL reset_outs_a: got %b want 0000",
                           {bus_a.ser_out, bus_a.ser_valid, bus_a.ser_par, bus_a.done});
      end
      n_cmp++;
      if ({bus_b.in_ready, bus_b.ser_valid, bus_b.done} !== 3'b000) begin
         n_err++; $display("FAIL reset_outs_b: got %b want 000",
                           {bus_b.in_ready, bus_b.ser_valid, bus_b.done});
      end
      rst = 1'b0;
      bus_a.in_valid = 1'b0;
      #1;
      n_cmp++;
      if (bus_a.in_ready !== 1'b1) begin
         n_err++; $display("FAIL release_in_ready: got %b want 1", bus_a.in_ready);
      end
      tick();
      n_cmp++;
      if (bus_a.ser_valid !== 1'b0) begin
         n_err++; $display("FAIL no_accept_in_rst: ser_valid got %b want 0", bus_a.ser_valid);
      end
   endtask

   task automatic test_basic();
      logic [8:0] bits, vals, pars;
      logic [9:0] dones;
      logic       rdy;
      xfer_a(8'hA5, 1'b0, 1'b0, bits, vals, pars, dones, rdy);
      n_cmp++;
      if (bits !== 9'h0A5) begin
         n_err++; $display("FAIL basic_bits: got %h want 0a5", bits);
      end
      n_cmp++;
      if (vals !== 9'h1FF) begin
         n_err++; $display("FAIL basic_valid: got %h want 1ff", vals);
      end
      n_cmp++;
      if (pars !== 9'h100) begin
         n_err++; $display("FAIL basic_par: got %h want 100", pars);
      end
      n_cmp++;
      if (dones !== 10'h200) begin
         n_err++; $display("FAIL basic_done: got %h want 200", dones);
      end
      n_cmp++;
      if (rdy !== 1'b0) begin
         n_err++; $display("FAIL basic_busy_ready: got %b want 0", rdy);
      end
      tick();
   endtask

   task automatic test_parity();
      logic [7:0] words [3] = '{8'hA5, 8'h07, 8'h00};
      logic       odds  [3] = '{1'b1, 1'b0, 1'b0};
      logic [8:0] exps  [3] = '{9'h1A5, 9'h107, 9'h000};
      logic [8:0] bits, vals, pars;
      logic [9:0] dones;
      logic       rdy;
      for (int k = 0; k < 3; k++) begin
         xfer_a(words[k], odds[k], 1'b0, bits, vals, pars, dones, rdy);
         n_cmp++;
         if (bits !== exps[k]) begin
            n_err++; $display("FAIL parity_%0d: got %h want %h", k, bits, exps[k]);
         end
      end
      tick();
   endtask

   task automatic test_div4();
      logic [35:0] sb, vb, pb, db;
      logic        d37, d38, v37;
      bus_b.in_data  = 8'h3C;
      bus_b.odd_sel  = 1'b0;
      bus_b.in_valid = 1'b1;
      tick();
      bus_b.in_valid = 1'b0;
      for (int i = 0; i < 36; i++) begin
         sb[i] = bus_b.ser_out;
         vb[i] = bus_b.ser_valid;
         pb[i] = bus_b.ser_par;
         db[i] = bus_b.done;
         tick();
      end
      d37 = bus_b.done;
      v37 = bus_b.ser_valid;
      tick();
      d38 = bus_b.done;
      n_cmp++;
      if (sb !== 36'h000FFFF00) begin
         n_err++; $display("FAIL div4_bits: got %h want 000ffff00", sb);
      end
      n_cmp++;
      if (vb !== 36'hFFFFFFFFF || v37 !== 1'b0) begin
         n_err++; $display("FAIL div4_valid: got %h/%b want fffffffff/0", vb, v37);
      end
      n_cmp++;
      if (pb !== 36'hF00000000) begin
         n_err++; $display("FAIL div4_par: got %h want f00000000", pb);
      end
      n_cmp++;
      if ({db, d37, d38} !== {36'h0, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL div4_done: got %h/%b/%b want 0/1/0", db, d37, d38);
      end
   endtask

   task automatic test_back_to_back();
      logic [19:0] sv, so, sp, dn, rd;
      bus_a.in_data  = 8'h01;
      bus_a.odd_sel  = 1'b0;
      bus_a.in_valid = 1'b1;
      tick();
      bus_a.in_data  = 8'hFF;
      for (int i = 0; i < 20; i++) begin
         sv[i] = bus_a.ser_valid;
         so[i] = bus_a.ser_out;
         sp[i] = bus_a.ser_par;
         dn[i] = bus_a.done;
         rd[i] = bus_a.in_ready;
         if (i == 10) bus_a.in_valid = 1'b0;
         tick();
      end
      n_cmp++;
      if (sv !== 20'h7FDFF) begin
         n_err++; $display("FAIL b2b_valid: got %h want 7fdff", sv);
      end
      n_cmp++;
      if (so !== 20'h3FD01) begin
         n_err++; $display("FAIL b2b_bits: got %h want 3fd01", so);
      end
      n_cmp++;
      if (sp !== 20'h40100) begin
         n_err++; $display("FAIL b2b_par: got %h want 40100", sp);
      end
      n_cmp++;
      if (dn !== 20'h80200 || rd !== 20'h80200) begin
         n_err++; $display("FAIL b2b_done_ready: got %h/%h want 80200/80200", dn, rd);
      end
   endtask

   task automatic test_reset_mid();
      logic [8:0] bits, vals, pars;
      logic [9:0] dones;
      logic       rdy, seen;
      bus_a.in_data  = 8'hFF;
      bus_a.odd_sel  = 1'b0;
      bus_a.in_valid = 1'b1;
      tick();
      bus_a.in_valid = 1'b0;
      tick();
      tick();
      tick();
      n_cmp++;
      if (bus_a.ser_out !== 1'b1 || bus_a.ser_valid !== 1'b1) begin
         n_err++; $display("FAIL mid_bit3: got %b%b want 11", bus_a.ser_out, bus_a.ser_valid);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus_a.in_ready !== 1'b0) begin
         n_err++; $display("FAIL mid_rst_ready: got %b want 0", bus_a.in_ready);
      end
      tick();
      n_cmp++;
      if ({bus_a.ser_out, bus_a.ser_valid, bus_a.ser_par, bus_a.done} !== 4'b0000) begin
         n_err++; $display("FAIL mid_rst_outs: got %b want 0000",
                           {bus_a.ser_out, bus_a.ser_valid, bus_a.ser_par, bus_a.done});
      end
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         seen = seen | bus_a.done | bus_a.ser_valid;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++; $display("FAIL mid_no_done: activity got %b want 0", seen);
      end
      xfer_a(8'h81, 1'b0, 1'b0, bits, vals, pars, dones, rdy);
      n_cmp++;
      if (bits !== 9'h081 || dones !== 10'h200) begin
         n_err++; $display("FAIL mid_recover: got %h/%h want 081/200", bits, dones);
      end
   endtask

   task automatic test_hold_inputs();
      logic [8:0] bits, vals, pars;
      logic [9:0] dones;
      logic       rdy;
      xfer_a(8'h5A, 1'b1, 1'b1, bits, vals, pars, dones, rdy);
      n_cmp++;
      if (bits !== 9'h15A || pars !== 9'h100) begin
         n_err++; $display("FAIL hold_5a: got %h/%h want 15a/100", bits, pars);
      end
      xfer_a(8'hC3, 1'b0, 1'b1, bits, vals, pars, dones, rdy);
      n_cmp++;
      if (bits !== 9'h0C3) begin
         n_err++; $display("FAIL hold_c3: got %h want 0c3", bits);
      end
      tick();
   endtask

   initial begin
      rst            = 1'b1;
      bus_a.in_data  = '0;
      bus_a.in_valid = 1'b0;
      bus_a.odd_sel  = 1'b0;
      bus_b.in_data  = '0;
      bus_b.in_valid = 1'b0;
      bus_b.odd_sel  = 1'b0;
      tick();
      test_reset();
      test_basic();
      test_parity();
      test_div4();
      test_back_to_back();
      test_reset_mid();
      test_hold_inputs();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
